mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequences a single-ported unified memory between the core's instruction-fetch port and data port in the 1-stage RV32 core. It allows one outstanding transaction at a time and alternates priority when both ports request in the same cycle. It routes each response back to the port that issued the request. A timeout counter recovers from a memory that never responds.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, cycles to wait for a response before abort; 0 disables the timeout
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_req_valid  in  1  fetch request
- imem_req_ready  out  1  fetch request accepted this cycle
- imem_req_addr  in  ADDR_W  fetch address
- imem_resp_valid  out  1  fetch data valid
- imem_resp_data  out  DATA_W  fetched instruction
- dmem_req_valid  in  1  data request
- dmem_req_ready  out  1  data request accepted this cycle
- dmem_req_addr  in  ADDR_W  data address
- dmem_req_data  in  DATA_W  store data
- dmem_req_fcn  in  1  M_XRD=0, M_XWR=1
- dmem_req_typ  in  3  MT_B/MT_H/MT_W/MT_BU/MT_HU
- dmem_resp_valid  out  1  load data valid, or store acknowledge
- dmem_resp_data  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts
- mem_req_addr, mem_req_data  out  ADDR_W, DATA_W  forwarded request fields
- mem_req_fcn  out  1  forwarded function; imem requests always drive M_XRD
- mem_req_typ  out  3  forwarded type; imem requests always drive MT_W
- mem_resp_valid  in  1  response present; exactly one response per accepted request, writes included
- mem_resp_data  in  DATA_W  response data
- timeout_err  out  1  one-cycle pulse when a transaction is aborted

## Operation
- States: IDLE, WAIT_I, WAIT_D.
- IDLE:
  - mem_req_valid = imem_req_valid | dmem_req_valid.
  - Request fields are muxed from the selected port.
  - The selected port's ready = mem_req_ready; the other port's ready = 0.
- Selection:
  - If only one port is valid, that port is selected.
  - If both are valid, the port named by the priority bit `pri` is selected (0 = dmem, 1 = imem).
- Acceptance (mem_req_valid & mem_req_ready in IDLE):
  - Go to WAIT_I or WAIT_D according to the selected port.
  - Clear the timeout counter.
  - `pri` points to the port not granted. It flips on every accept, including uncontended ones.
- WAIT_x with mem_resp_valid:
  - x_resp_valid = 1 and x_resp_data = mem_resp_data, combinationally.
  - Return to IDLE.
- WAIT_x without mem_resp_valid: the counter increments.
  - When the counter reaches TIMEOUT and TIMEOUT != 0: x_resp_valid = 1, x_resp_data = 0, timeout_err = 1 in that cycle, then go to IDLE.
- In WAIT states: mem_req_valid = 0 and both readys = 0.
- mem_resp_valid in IDLE is ignored. This covers stray responses and responses that arrive after a reset.
- Requesters hold valid and fields stable until ready is seen. The arbiter does not latch request fields.

## Timing
- Reset values:
  - state = IDLE, pri = 0 (dmem first), counter = 0.
  - All resp_valid outputs and timeout_err = 0.
  - Data outputs = 0 while not valid.
- Latency:
  - Request accepted in cycle N.
  - Response forwarded in the same cycle it arrives, earliest N+1.
  - Next request accepted earliest in the cycle after the response.
  - Peak throughput is 1 transaction per 2 cycles.
- Timeout fires on cycle N+TIMEOUT if no response has arrived by then.
- A response arriving in the timeout cycle itself wins: real data is delivered and no timeout_err is raised.
- Reset mid-transaction returns immediately to IDLE. The outstanding response is discarded.
- The counter is 8 bits wide; TIMEOUT ≤ 255.

## Structure
- Shared package mem_pkg holds:
  - M_XRD/M_XWR constants.
  - MT_* type constants.
  - typedef enum for the arbiter state.
- Sub-module: none. The 2-way priority picker and the timeout counter are small enough to be inline.

## Test plan
- Lone fetch at addr 0x200, memory responds 1 cycle later with 0x00000013 → imem_resp_valid for 1 cycle with 0x00000013; dmem_resp_valid stays 0.
- Both ports valid after reset, both responses 2 cycles late → order is dmem, then imem, then dmem; `pri` alternates.
- Store: dmem addr 0x1000, data 0xDEADBEEF, fcn=M_XWR, typ=MT_B → memory sees identical fields; store acknowledge arrives on dmem_resp_valid.
- mem_req_ready held low for 5 cycles with a fetch pending → imem_req_ready is 0 throughout and the request fields stay stable; grant occurs on the first ready.
- TIMEOUT=4, no response → on cycle N+4, imem_resp_valid=1 with data 0 and timeout_err=1; next request accepted on N+5. A response arriving on N+6 is ignored.
- rst asserted during WAIT_D → state is IDLE immediately; a late mem_resp_valid produces no dmem_resp_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: memory command, access-type and arbiter state definitions shared by the core memory blocks
package mem_pkg;
  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;
  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd4;
  localparam logic [2:0] MT_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter sharing one memory port between fetch and data ports, with response timeout
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_req_valid,
  output logic              imem_req_ready,
  input  logic [ADDR_W-1:0] imem_req_addr,
  output logic              imem_resp_valid,
  output logic [DATA_W-1:0] imem_resp_data,
  input  logic              dmem_req_valid,
  output logic              dmem_req_ready,
  input  logic [ADDR_W-1:0] dmem_req_addr,
  input  logic [DATA_W-1:0] dmem_req_data,
  input  logic              dmem_req_fcn,
  input  logic [2:0]        dmem_req_typ,
  output logic              dmem_resp_valid,
  output logic [DATA_W-1:0] dmem_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              mem_req_fcn,
  output logic [2:0]        mem_req_typ,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              timeout_err
);
  arb_state_t state, state_n;
  logic pri;
  logic [7:0] cnt;
  logic idle, sel_i, accept, timed, done;
  always_comb begin
    idle            = state == IDLE;
    sel_i           = imem_req_valid & (~dmem_req_valid | pri);
    mem_req_valid   = idle & (imem_req_valid | dmem_req_valid);
    accept          = mem_req_valid & mem_req_ready;
    imem_req_ready  = idle & sel_i & mem_req_ready;
    dmem_req_ready  = idle & ~sel_i & dmem_req_valid & mem_req_ready;
    mem_req_addr    = sel_i ? imem_req_addr : dmem_req_addr;
    mem_req_data    = sel_i ? '0 : dmem_req_data;
    mem_req_fcn     = sel_i ? M_XRD : dmem_req_fcn;
    mem_req_typ     = sel_i ? MT_W : dmem_req_typ;
    timed           = ~idle & ~mem_resp_valid & (TIMEOUT != 0) & ({1'b0, cnt} + 9'd1 == 9'(TIMEOUT));
    done            = ~idle & (mem_resp_valid | timed);
    timeout_err     = timed;
    imem_resp_valid = (state == WAIT_I) & done;
    dmem_resp_valid = (state == WAIT_D) & done;
    imem_resp_data  = (state == WAIT_I) & mem_resp_valid ? mem_resp_data : '0;
    dmem_resp_data  = (state == WAIT_D) & mem_resp_valid ? mem_resp_data : '0;
    state_n         = accept ? (sel_i ? WAIT_I : WAIT_D) : done ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pri   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        pri <= ~pri;
        cnt <= '0;
      end else if (~idle & ~mem_resp_valid) begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level reference model checked every cycle
module tb_mem_arbiter;
  import mem_pkg::*;
  localparam int TO = 4;
  logic clk, rst;
  logic imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic dmem_req_valid, dmem_req_ready, dmem_req_fcn, dmem_resp_valid;
  logic [31:0] dmem_req_addr, dmem_req_data, dmem_resp_data;
  logic [2:0] dmem_req_typ, mem_req_typ;
  logic mem_req_valid, mem_req_ready, mem_req_fcn, mem_resp_valid, timeout_err;
  logic [31:0] mem_req_addr, mem_req_data, mem_resp_data;
  int npass = 0, ntot = 0;
  int outp = 0, age = 0;
  bit pri_m = 0, gi, timed;
  int grants[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_addr(dmem_req_addr),
    .dmem_req_data(dmem_req_data), .dmem_req_fcn(dmem_req_fcn), .dmem_req_typ(dmem_req_typ),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .timeout_err(timeout_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      outp  = 0;
      age   = 0;
      pri_m = 0;
    end
    if (outp == 0) begin
      gi = imem_req_valid && (!dmem_req_valid || pri_m);
      chk("m_mrv", 32'(mem_req_valid), 32'(imem_req_valid | dmem_req_valid));
      chk("m_irdy", 32'(imem_req_ready), 32'(gi && mem_req_ready));
      chk("m_drdy", 32'(dmem_req_ready), 32'(!gi && dmem_req_valid && mem_req_ready));
      if (imem_req_valid || dmem_req_valid) begin
        chk("m_addr", mem_req_addr, gi ? imem_req_addr : dmem_req_addr);
        chk("m_fcn", 32'(mem_req_fcn), gi ? 32'(M_XRD) : 32'(dmem_req_fcn));
        chk("m_typ", 32'(mem_req_typ), gi ? 32'(MT_W) : 32'(dmem_req_typ));
        if (!gi) chk("m_wdata", mem_req_data, dmem_req_data);
      end
      chk("m_ivld_idle", 32'(imem_resp_valid), 0);
      chk("m_dvld_idle", 32'(dmem_resp_valid), 0);
      chk("m_idata_idle", imem_resp_data, 0);
      chk("m_ddata_idle", dmem_resp_data, 0);
      chk("m_to_idle", 32'(timeout_err), 0);
      if (!rst && (imem_req_valid || dmem_req_valid) && mem_req_ready) begin
        outp  = gi ? 1 : 2;
        age   = 1;
        pri_m = !pri_m;
        grants.push_back(outp);
      end
    end else begin
      timed = !mem_resp_valid && age == TO;
      chk("m_mrv_wait", 32'(mem_req_valid), 0);
      chk("m_irdy_wait", 32'(imem_req_ready), 0);
      chk("m_drdy_wait", 32'(dmem_req_ready), 0);
      chk("m_ivld", 32'(imem_resp_valid), 32'(outp == 1 && (mem_resp_valid || timed)));
      chk("m_dvld", 32'(dmem_resp_valid), 32'(outp == 2 && (mem_resp_valid || timed)));
      chk("m_idata", imem_resp_data, (outp == 1 && mem_resp_valid) ? mem_resp_data : 0);
      chk("m_ddata", dmem_resp_data, (outp == 2 && mem_resp_valid) ? mem_resp_data : 0);
      chk("m_to", 32'(timeout_err), 32'(timed));
      if (mem_resp_valid || timed) outp = 0;
      else age++;
    end
  end

  initial begin
    rst = 1;
    imem_req_valid = 0; imem_req_addr = 0;
    dmem_req_valid = 0; dmem_req_addr = 0; dmem_req_data = 0; dmem_req_fcn = M_XRD; dmem_req_typ = MT_W;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    step(); step(); #1;
    chk("rst_mrv", 32'(mem_req_valid), 0);
    chk("rst_ivld", 32'(imem_resp_valid), 0);
    chk("rst_dvld", 32'(dmem_resp_valid), 0);
    chk("rst_to", 32'(timeout_err), 0);
    rst = 0;
    step();
    imem_req_valid = 1; imem_req_addr = 32'h100;
    dmem_req_valid = 1; dmem_req_addr = 32'h300; mem_req_ready = 1;
    #1;
    chk("c1_drdy", 32'(dmem_req_ready), 1);
    chk("c1_irdy", 32'(imem_req_ready), 0);
    chk("c1_addr", mem_req_addr, 32'h300);
    step(); step();
    mem_resp_valid = 1; mem_resp_data = 32'hAAAA0001; #1;
    chk("c1_dvld", 32'(dmem_resp_valid), 1);
    chk("c1_ddata", dmem_resp_data, 32'hAAAA0001);
    step(); mem_resp_valid = 0; #1;
    chk("c2_irdy", 32'(imem_req_ready), 1);
    chk("c2_addr", mem_req_addr, 32'h100);
    step(); step();
    mem_resp_valid = 1; mem_resp_data = 32'hBBBB0002; #1;
    chk("c2_ivld", 32'(imem_resp_valid), 1);
    chk("c2_idata", imem_resp_data, 32'hBBBB0002);
    step(); mem_resp_valid = 0; #1;
    chk("c3_drdy", 32'(dmem_req_ready), 1);
    step(); imem_req_valid = 0; dmem_req_valid = 0;
    step(); mem_resp_valid = 1; mem_resp_data = 32'hCCCC0003; #1;
    chk("c3_ddata", dmem_resp_data, 32'hCCCC0003);
    step(); mem_resp_valid = 0;
    chk("order_n", 32'(grants.size()), 3);
    if (grants.size() == 3) begin
      chk("order0", 32'(grants[0]), 2);
      chk("order1", 32'(grants[1]), 1);
      chk("order2", 32'(grants[2]), 2);
    end
    imem_req_valid = 1; imem_req_addr = 32'h200; #1;
    chk("f_irdy", 32'(imem_req_ready), 1);
    step(); imem_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h00000013; #1;
    chk("f_ivld", 32'(imem_resp_valid), 1);
    chk("f_idata", imem_resp_data, 32'h00000013);
    chk("f_dvld", 32'(dmem_resp_valid), 0);
    step(); mem_resp_valid = 0; #1;
    chk("f_ivld_end", 32'(imem_resp_valid), 0);
    dmem_req_valid = 1; dmem_req_addr = 32'h1000; dmem_req_data = 32'hDEADBEEF;
    dmem_req_fcn = M_XWR; dmem_req_typ = MT_B; #1;
    chk("s_addr", mem_req_addr, 32'h1000);
    chk("s_data", mem_req_data, 32'hDEADBEEF);
    chk("s_fcn", 32'(mem_req_fcn), 32'(M_XWR));
    chk("s_typ", 32'(mem_req_typ), 32'(MT_B));
    chk("s_drdy", 32'(dmem_req_ready), 1);
    step(); dmem_req_valid = 0; dmem_req_fcn = M_XRD; dmem_req_typ = MT_W;
    mem_resp_valid = 1; mem_resp_data = 0; #1;
    chk("s_ack", 32'(dmem_resp_valid), 1);
    step(); mem_resp_valid = 0;
    imem_req_valid = 1; imem_req_addr = 32'h400; mem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("r_irdy_low", 32'(imem_req_ready), 0);
      chk("r_mrv", 32'(mem_req_valid), 1);
      chk("r_addr", mem_req_addr, 32'h400);
      step();
    end
    mem_req_ready = 1; #1;
    chk("r_grant", 32'(imem_req_ready), 1);
    step(); imem_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h55;
    step(); mem_resp_valid = 0;
    imem_req_valid = 1; imem_req_addr = 32'h500; #1;
    chk("t_irdy", 32'(imem_req_ready), 1);
    step(); imem_req_valid = 0;
    for (int i = 1; i < TO; i++) begin
      #1;
      chk("t_ivld_early", 32'(imem_resp_valid), 0);
      chk("t_to_early", 32'(timeout_err), 0);
      step();
    end
    #1;
    chk("t_ivld", 32'(imem_resp_valid), 1);
    chk("t_idata", imem_resp_data, 0);
    chk("t_err", 32'(timeout_err), 1);
    step();
    imem_req_valid = 1; imem_req_addr = 32'h510; mem_req_ready = 0; #1;
    chk("t_idle_after", 32'(mem_req_valid), 1);
    step(); imem_req_valid = 0; mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 32'h77; #1;
    chk("t_late_ivld", 32'(imem_resp_valid), 0);
    chk("t_late_dvld", 32'(dmem_resp_valid), 0);
    chk("t_late_to", 32'(timeout_err), 0);
    step(); mem_resp_valid = 0;
    imem_req_valid = 1; imem_req_addr = 32'h520;
    step(); imem_req_valid = 0;
    step(); step(); step();
    mem_resp_valid = 1; mem_resp_data = 32'h99; #1;
    chk("w_ivld", 32'(imem_resp_valid), 1);
    chk("w_idata", imem_resp_data, 32'h99);
    chk("w_to", 32'(timeout_err), 0);
    step(); mem_resp_valid = 0;
    dmem_req_valid = 1; dmem_req_addr = 32'h700; #1;
    chk("x_drdy", 32'(dmem_req_ready), 1);
    step(); dmem_req_valid = 0;
    #1 rst = 1; imem_req_valid = 1;
    #1;
    chk("x_idle", 32'(mem_req_valid), 1);
    imem_req_valid = 0;
    step(); rst = 0; mem_resp_valid = 1; mem_resp_data = 32'h88; #1;
    chk("x_dvld", 32'(dmem_resp_valid), 0);
    chk("x_ivld", 32'(imem_resp_valid), 0);
    step(); mem_resp_valid = 0;
    step(); step();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
